// File: rtl/actuador_pkg.sv
// Shared types and helpers for the two-axis stepper actuator.
// Axis state encoding, speed codes, angle width and the speed-to-period mapping.
package actuador_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_POS = 2'd1,
    RUN_NEG = 2'd2,
    FAULT   = 2'd3
  } eje_state_t;

  localparam logic [1:0] SPD_STOP = 2'b00;
  localparam logic [1:0] SPD_SLOW = 2'b01;
  localparam logic [1:0] SPD_MED  = 2'b10;
  localparam logic [1:0] SPD_FAST = 2'b11;

  localparam int ANG_W = 16;

  // Clock cycles per step for a speed code; never returns 0 so the prescaler compare stays sane.
  function automatic logic [15:0] step_period(input logic [1:0] code, input logic [15:0] base);
    logic [15:0] p;
    case (code)
      SPD_SLOW: p = base;
      SPD_MED:  p = base >> 1;
      SPD_FAST: p = base >> 2;
      default:  p = base;
    endcase
    if (p == 16'd0) p = 16'd1;
    return p;
  endfunction

endpackage

// File: rtl/eje_paso.sv
// Single-axis engine: direction FSM, step prescaler, coil phase and saturating angle.
// Honours ACTUADOR_HOLD_EN (keep last coil phase energized in IDLE/FAULT).
module eje_paso
  import actuador_pkg::*;
#(
  parameter int STEP_DIV_BASE = 50000,
  parameter int ANG_MAX       = 180,
  parameter int ANG_RESET     = 90
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pos,
  input  logic [1:0]       neg,
  output logic [3:0]       coil,
  output logic [ANG_W-1:0] angle,
  output logic             lim,
  output logic             conflict
);

  localparam logic [15:0]      BASE_W  = 16'(STEP_DIV_BASE);
  localparam logic [ANG_W-1:0] MAX_W   = ANG_W'(ANG_MAX);
  localparam logic [ANG_W-1:0] RESET_W = ANG_W'(ANG_RESET);

  eje_state_t       state_reg, state_next;
  logic [15:0]      cnt_reg;
  logic [1:0]       phase_reg;
  logic [ANG_W-1:0] angle_reg;
  logic             lim_reg;

  logic [1:0]  code;
  logic [15:0] period;
  logic        in_run, run_next, stay_run, tick;

  always_comb begin
    state_next = state_reg;
    if (pos != SPD_STOP && neg != SPD_STOP) begin
      state_next = FAULT;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pos != SPD_STOP)      state_next = RUN_POS;
          else if (neg != SPD_STOP) state_next = RUN_NEG;
        end
        RUN_POS: begin
          if (pos == SPD_STOP) state_next = (neg != SPD_STOP) ? RUN_NEG : IDLE;
        end
        RUN_NEG: begin
          if (neg == SPD_STOP) state_next = (pos != SPD_STOP) ? RUN_POS : IDLE;
        end
        FAULT: begin
          if (pos == SPD_STOP && neg == SPD_STOP) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A tick only fires while the axis holds its RUN state; any state change clears the prescaler instead.
  always_comb begin
    in_run   = (state_reg == RUN_POS) || (state_reg == RUN_NEG);
    run_next = (state_next == RUN_POS) || (state_next == RUN_NEG);
    code     = (state_reg == RUN_NEG) ? neg : pos;
    period   = step_period(code, BASE_W);
    stay_run = in_run && (state_next == state_reg);
    tick     = stay_run && (cnt_reg >= period - 16'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'd0;
      phase_reg <= 2'd0;
      angle_reg <= RESET_W;
      lim_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (!stay_run || tick) cnt_reg <= 16'd0;
      else                   cnt_reg <= cnt_reg + 16'd1;

      if (!run_next) begin
        lim_reg <= 1'b0;
      end else if (tick && state_reg == RUN_POS) begin
        if (angle_reg < MAX_W) begin
          phase_reg <= phase_reg + 2'd1;
          angle_reg <= angle_reg + 1'b1;
          lim_reg   <= 1'b0;
        end else begin
          lim_reg <= 1'b1;
        end
      end else if (tick && state_reg == RUN_NEG) begin
        if (angle_reg != '0) begin
          phase_reg <= phase_reg - 2'd1;
          angle_reg <= angle_reg - 1'b1;
          lim_reg   <= 1'b0;
        end else begin
          lim_reg <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    coil = 4'b0000;
`ifdef ACTUADOR_HOLD_EN
    coil = 4'b0001 << phase_reg;
`else
    if (in_run) coil = 4'b0001 << phase_reg;
`endif
  end

  assign angle    = angle_reg;
  assign lim      = lim_reg;
  assign conflict = (state_reg == FAULT);

endmodule

// File: rtl/actuador_ejes.sv
// Two independent stepper axis engines (theta, phi) with a shared fault flag.
// Optional macro ACTUADOR_HOLD_EN keeps holding torque on the last phase when idle.
module actuador_ejes
  import actuador_pkg::*;
#(
  parameter int STEP_DIV_BASE = 50000,
  parameter int ANG_MAX       = 180,
  parameter int ANG_RESET     = 90
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       s_in_theta_pos,
  input  logic [1:0]       s_in_theta_neg,
  input  logic [1:0]       s_in_phi_pos,
  input  logic [1:0]       s_in_phi_neg,
  output logic [3:0]       coil_theta,
  output logic [3:0]       coil_phi,
  output logic [ANG_W-1:0] theta_actual,
  output logic [ANG_W-1:0] phi_actual,
  output logic             lim_theta,
  output logic             lim_phi,
  output logic             fault
);

  // Index 0 is theta, index 1 is phi.
  logic [1:0]       pos_a      [2];
  logic [1:0]       neg_a      [2];
  logic [3:0]       coil_a     [2];
  logic [ANG_W-1:0] angle_a    [2];
  logic [1:0]       lim_a;
  logic [1:0]       conflict_a;

  assign pos_a[0] = s_in_theta_pos;
  assign neg_a[0] = s_in_theta_neg;
  assign pos_a[1] = s_in_phi_pos;
  assign neg_a[1] = s_in_phi_neg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_eje
      eje_paso #(
        .STEP_DIV_BASE(STEP_DIV_BASE),
        .ANG_MAX      (ANG_MAX),
        .ANG_RESET    (ANG_RESET)
      ) u_eje (
        .clk     (clk),
        .rst     (rst),
        .pos     (pos_a[gi]),
        .neg     (neg_a[gi]),
        .coil    (coil_a[gi]),
        .angle   (angle_a[gi]),
        .lim     (lim_a[gi]),
        .conflict(conflict_a[gi])
      );
    end
  endgenerate

  assign coil_theta   = coil_a[0];
  assign coil_phi     = coil_a[1];
  assign theta_actual = angle_a[0];
  assign phi_actual   = angle_a[1];
  assign lim_theta    = lim_a[0];
  assign lim_phi      = lim_a[1];
  assign fault        = |conflict_a;

endmodule

// File: tb/tb_actuador_ejes.sv
// Directed bench for actuador_ejes: vector table for run/reverse/fault, hand sequences
// for the angle limit, mid-run speed change and asynchronous reset.
module tb_actuador_ejes;

`ifdef ACTUADOR_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  tp, tn, pp, pn;
  logic [3:0]  coil_theta, coil_phi;
  logic [15:0] theta_actual, phi_actual;
  logic        lim_theta, lim_phi, fault;

  int total = 0;
  int bad   = 0;

  actuador_ejes #(
    .STEP_DIV_BASE(8),
    .ANG_MAX      (180),
    .ANG_RESET    (90)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_in_theta_pos(tp),
    .s_in_theta_neg(tn),
    .s_in_phi_pos  (pp),
    .s_in_phi_neg  (pn),
    .coil_theta    (coil_theta),
    .coil_phi      (coil_phi),
    .theta_actual  (theta_actual),
    .phi_actual    (phi_actual),
    .lim_theta     (lim_theta),
    .lim_phi       (lim_phi),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  tp, tn, pp, pn;
    int          n;
    logic [15:0] th, ph;
    logic [3:0]  ct, cp;
    logic        lt, lp, f;
  } vec_t;

  function automatic vec_t mk(string nm, logic [1:0] a, logic [1:0] b, logic [1:0] c, logic [1:0] d,
                              int n, int th, int ph, logic [3:0] ct, logic [3:0] cp,
                              logic lt, logic lp, logic f);
    vec_t v;
    v.name = nm; v.tp = a; v.tn = b; v.pp = c; v.pn = d; v.n = n;
    v.th = 16'(th); v.ph = 16'(ph); v.ct = ct; v.cp = cp; v.lt = lt; v.lp = lp; v.f = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vecs[18];
  logic [3:0] ti, pi, rc, ec;
  logic [15:0] eph;

  initial begin
    ti = HOLD ? 4'b0010 : 4'b0000;  // theta idle coil once phase is 1
    pi = HOLD ? 4'b0001 : 4'b0000;  // phi idle coil at phase 0
    rc = HOLD ? 4'b0001 : 4'b0000;  // coil right after reset

    vecs[0]  = mk("enter_pos",  2'b01, 2'b00, 2'b00, 2'b00, 1, 90, 90, 4'b0001, pi, 0, 0, 0);
    vecs[1]  = mk("pre_tick",   2'b01, 2'b00, 2'b00, 2'b00, 7, 90, 90, 4'b0001, pi, 0, 0, 0);
    vecs[2]  = mk("tick1",      2'b01, 2'b00, 2'b00, 2'b00, 1, 91, 90, 4'b0010, pi, 0, 0, 0);
    vecs[3]  = mk("tick2",      2'b01, 2'b00, 2'b00, 2'b00, 8, 92, 90, 4'b0100, pi, 0, 0, 0);
    vecs[4]  = mk("tick3",      2'b01, 2'b00, 2'b00, 2'b00, 8, 93, 90, 4'b1000, pi, 0, 0, 0);
    vecs[5]  = mk("tick4",      2'b01, 2'b00, 2'b00, 2'b00, 8, 94, 90, 4'b0001, pi, 0, 0, 0);
    vecs[6]  = mk("tick5",      2'b01, 2'b00, 2'b00, 2'b00, 8, 95, 90, 4'b0010, pi, 0, 0, 0);
    vecs[7]  = mk("stop",       2'b00, 2'b00, 2'b00, 2'b00, 1, 95, 90, ti,      pi, 0, 0, 0);
    vecs[8]  = mk("enter_neg",  2'b00, 2'b01, 2'b00, 2'b00, 1, 95, 90, 4'b0010, pi, 0, 0, 0);
    vecs[9]  = mk("neg_tick",   2'b00, 2'b01, 2'b00, 2'b00, 8, 94, 90, 4'b0001, pi, 0, 0, 0);
    vecs[10] = mk("reverse",    2'b01, 2'b00, 2'b00, 2'b00, 1, 94, 90, 4'b0001, pi, 0, 0, 0);
    vecs[11] = mk("rev_wait",   2'b01, 2'b00, 2'b00, 2'b00, 7, 94, 90, 4'b0001, pi, 0, 0, 0);
    vecs[12] = mk("rev_tick",   2'b01, 2'b00, 2'b00, 2'b00, 1, 95, 90, 4'b0010, pi, 0, 0, 0);
    vecs[13] = mk("stop2",      2'b00, 2'b00, 2'b00, 2'b00, 1, 95, 90, ti,      pi, 0, 0, 0);
    vecs[14] = mk("conflict",   2'b01, 2'b10, 2'b00, 2'b00, 1, 95, 90, ti,      pi, 0, 0, 1);
    vecs[15] = mk("fault_hold", 2'b01, 2'b10, 2'b00, 2'b00, 10, 95, 90, ti,     pi, 0, 0, 1);
    vecs[16] = mk("half_clear", 2'b00, 2'b10, 2'b00, 2'b00, 1, 95, 90, ti,      pi, 0, 0, 1);
    vecs[17] = mk("clear",      2'b00, 2'b00, 2'b00, 2'b00, 1, 95, 90, ti,      pi, 0, 0, 0);

    rst = 1'b0;
    tp = 2'b00; tn = 2'b00; pp = 2'b00; pn = 2'b00;
    step(3);
    rst = 1'b1;
    #1;
    chk("rst_coil_theta", coil_theta, rc);
    chk("rst_coil_phi", coil_phi, rc);
    chk("rst_theta", theta_actual, 90);
    chk("rst_phi", phi_actual, 90);
    chk("rst_fault", fault, 0);
    chk("rst_lim", {lim_theta, lim_phi}, 0);
    step(1);
    chk("idle_theta", theta_actual, 90);
    $display("txn reset: theta=%0d phi=%0d fault=%0b", theta_actual, phi_actual, fault);

    for (int i = 0; i < 18; i++) begin
      tp = vecs[i].tp; tn = vecs[i].tn; pp = vecs[i].pp; pn = vecs[i].pn;
      step(vecs[i].n);
      chk({vecs[i].name, "_theta"}, theta_actual, vecs[i].th);
      chk({vecs[i].name, "_phi"}, phi_actual, vecs[i].ph);
      chk({vecs[i].name, "_coil_theta"}, coil_theta, vecs[i].ct);
      chk({vecs[i].name, "_coil_phi"}, coil_phi, vecs[i].cp);
      chk({vecs[i].name, "_lim_theta"}, lim_theta, vecs[i].lt);
      chk({vecs[i].name, "_lim_phi"}, lim_phi, vecs[i].lp);
      chk({vecs[i].name, "_fault"}, fault, vecs[i].f);
      $display("txn %s: theta=%0d coil_theta=%b fault=%0b", vecs[i].name, theta_actual, coil_theta, fault);
    end

    // Phi driven down at period 2: after 88 ticks it sits at 2, then hits 0 and stalls.
    pn = 2'b11;
    step(177);
    chk("phi_at_2", phi_actual, 2);
    chk("phi_coil_at_2", coil_phi, 4'b0001);
    for (int c = 1; c <= 10; c++) begin
      step(1);
      eph = (c < 2) ? 16'd2 : (c < 4) ? 16'd1 : 16'd0;
      ec  = (c < 2) ? 4'b0001 : (c < 4) ? 4'b1000 : 4'b0100;
      chk($sformatf("lim_phi_c%0d", c), phi_actual, eph);
      chk($sformatf("lim_coil_c%0d", c), coil_phi, ec);
      chk($sformatf("lim_flag_c%0d", c), lim_phi, (c >= 6) ? 1 : 0);
      $display("txn phi_limit c=%0d: phi=%0d coil=%b lim=%0b", c, phi_actual, coil_phi, lim_phi);
    end
    chk("lim_theta_quiet", lim_theta, 0);
    pn = 2'b00;
    step(1);
    chk("lim_phi_release", lim_phi, 0);
    chk("phi_hold_0", phi_actual, 0);
    chk("phi_idle_coil", coil_phi, HOLD ? 4'b0100 : 4'b0000);

    // Speed change with prescaler at 5: tick on the next edge, then every 2 cycles.
    tp = 2'b01;
    step(6);
    chk("spd_pre", theta_actual, 95);
    tp = 2'b11;
    step(1);
    chk("spd_tick_now", theta_actual, 96);
    chk("spd_coil", coil_theta, 4'b0100);
    step(1);
    chk("spd_gap", theta_actual, 96);
    step(1);
    chk("spd_tick2", theta_actual, 97);
    step(2);
    chk("spd_tick3", theta_actual, 98);
    $display("txn speed_change: theta=%0d", theta_actual);

    step(44);
    chk("run_to_120", theta_actual, 120);
    chk("coil_at_120", coil_theta, 4'b0100);

    // Asynchronous reset mid-run, between clock edges.
    rst = 1'b0;
    #1;
    chk("async_theta", theta_actual, 90);
    chk("async_phi", phi_actual, 90);
    chk("async_coil_theta", coil_theta, rc);
    chk("async_coil_phi", coil_phi, rc);
    chk("async_fault", fault, 0);
    step(2);
    rst = 1'b1;
    step(1);
    chk("post_rst_e0", theta_actual, 90);
    chk("post_rst_coil", coil_theta, 4'b0001);
    step(1);
    chk("post_rst_e1", theta_actual, 90);
    step(1);
    chk("post_rst_e2", theta_actual, 91);
    $display("txn async_reset: theta=%0d", theta_actual);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
